// File: rtl/lcd_capture.sv
// LCD pixel stream capture: rebuilds 2bpp frames from the PPU stream, packs 4 pixels
// per byte and writes them into the back bank of a double-buffered frame buffer.
module lcd_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144,
    parameter int AW     = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          hs,
    input  logic          vs,
    input  logic          cpl,
    input  logic [1:0]    pixel,
    input  logic          valid,
    output logic          fb_wr,
    output logic          fb_bank,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_data,
    output logic          disp_bank,
    output logic          frame_done,
    output logic          frame_drop,
    output logic [7:0]    frame_cnt,
    output logic          dbg_state
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] X_END      = XW'(WIDTH);
    localparam logic [YW-1:0] Y_END      = YW'(HEIGHT);
    localparam logic [AW-1:0] LINE_BYTES = AW'(WIDTH / 4);

    localparam logic [0:0] SYNC    = 1'b0;
    localparam logic [0:0] CAPTURE = 1'b1;

    logic [0:0]    state, state_n;
    logic          hs_q, vs_q, cpl_q;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [AW-1:0] line_base, lb_n;
    logic [1:0]    phase, ph_n;
    logic          err, err_n;
    logic [5:0]    shreg, sh_n;
    logic          wr_n, disp_n, done_n, drop_n;
    logic [AW-1:0] addr_n;
    logic [7:0]    data_n, cnt_n;

    logic cpl_rise, hs_fall, vs_fall;
    assign cpl_rise = cpl & ~cpl_q;
    assign hs_fall  = ~hs & hs_q;
    assign vs_fall  = ~vs & vs_q;

    assign fb_bank   = ~disp_bank;
    assign dbg_state = state;

    // Same-edge events are applied in order: pixel, line end, frame end; each
    // stage works on the values left by the previous one.
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        lb_n    = line_base;
        ph_n    = phase;
        err_n   = err;
        sh_n    = shreg;
        wr_n    = 1'b0;
        addr_n  = fb_addr;
        data_n  = fb_data;
        disp_n  = disp_bank;
        done_n  = 1'b0;
        drop_n  = 1'b0;
        cnt_n   = frame_cnt;
        case (state)
            SYNC: begin
                if (vs_fall && en) begin
                    state_n = CAPTURE;
                    x_n     = '0;
                    y_n     = '0;
                    lb_n    = '0;
                    ph_n    = '0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                if (!en) begin
                    state_n = SYNC;
                end else begin
                    if (cpl_rise && valid) begin
                        if (x < X_END && y < Y_END) begin
                            sh_n = {shreg[3:0], pixel};
                            x_n  = x + XW'(1);
                            ph_n = phase + 2'd1;
                            if (phase == 2'd3) begin
                                wr_n   = 1'b1;
                                data_n = {shreg, pixel};
                                addr_n = line_base + AW'(x[XW-1:2]);
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    if (hs_fall) begin
                        if (x_n != X_END) err_n = 1'b1;
                        x_n  = '0;
                        ph_n = '0;
                        if (y_n < Y_END) begin
                            y_n  = y_n + YW'(1);
                            lb_n = lb_n + LINE_BYTES;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    if (vs_fall) begin
                        if (y_n == Y_END && !err_n) begin
                            done_n = 1'b1;
                            disp_n = ~disp_bank;
                            cnt_n  = frame_cnt + 8'd1;
                        end else begin
                            drop_n = 1'b1;
                        end
                        x_n   = '0;
                        y_n   = '0;
                        lb_n  = '0;
                        ph_n  = '0;
                        err_n = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SYNC;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            cpl_q      <= 1'b0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= '0;
            err        <= 1'b0;
            shreg      <= '0;
            fb_wr      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            disp_bank  <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            hs_q       <= hs;
            vs_q       <= vs;
            cpl_q      <= cpl;
            x          <= x_n;
            y          <= y_n;
            line_base  <= lb_n;
            phase      <= ph_n;
            err        <= err_n;
            shreg      <= sh_n;
            fb_wr      <= wr_n;
            fb_addr    <= addr_n;
            fb_data    <= data_n;
            disp_bank  <= disp_n;
            frame_done <= done_n;
            frame_drop <= drop_n;
            frame_cnt  <= cnt_n;
        end
    end
endmodule
